uart_transmitter: RTL and testbench

//   Serial-to-parallel line deserializer: one rx sample per clk, no oversampling.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_transmitter.sv | 72 +++++++
 tb/tb_uart_transmitter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the serial line receiver.
`timescale 1ns / 1ps
package uart_pkg;

    // Default frame width; also the width of the parallel output word.
    localparam int unsigned DataBitsDefault = 8;

    typedef enum logic [0:0] {
        IDLE,
        DATA
    } state_e;

endpackage

// File: rtl/uart_transmitter.sv
// Serial-to-parallel line deserializer: one rx sample per clock, no oversampling.
// A low sample while idle is the start bit; the next DATA_BITS samples are shifted in
// MSB-first. rdy rises on the edge that shifts the last bit and holds until the next
// start bit. There is no stop-bit phase, so frames may run back to back.
`timescale 1ns / 1ps
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DataBitsDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data
);

    localparam int unsigned    CntW    = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BITS - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  rdy_q, rdy_d;

    // Next-state: hunt for a start bit while idle, shift one bit per edge while in a frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                // data is deliberately kept; only rdy drops when a new frame begins
                if (!rx) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                end
            end
            DATA: begin
                data_d = {data_q[DATA_BITS-2:0], rx};
                cnt_d  = cnt_q + 1'b1;
                // Word is complete on this same edge: no extra latency to rdy
                if (cnt_q == LastCnt) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset; a reset mid-frame aborts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rdy  = rdy_q;
    assign data = data_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: MSB-first shifting, rdy timing, idle hold,
// back-to-back start with retained data, and asynchronous mid-frame reset.
`timescale 1ns / 1ps
module tb_uart_transmitter;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rdy;
    logic [7:0] data;

    int checks = 0;
    int errors = 0;

    uart_transmitter #(
        .DATA_BITS(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .rdy  (rdy),
        .data (data)
    );

    // 2-unit clock: rising edges at t=1,3,5,...
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic chk_data(input string tag, input logic [7:0] exp);
        checks++;
        assert (data === exp)
        else begin
            errors++;
            $error("FAIL %s data observed %b expected %b", tag, data, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        checks++;
        assert (rdy === exp)
        else begin
            errors++;
            $error("FAIL %s rdy observed %b expected %b", tag, rdy, exp);
        end
    endtask

    // Drive rx before a rising edge, return on the following falling edge.
    task automatic step(input logic v);
        rx = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] frame;
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_data("reset_data", 8'h00);
        chk_rdy("reset_rdy", 1'b0);
        rst_n = 1'b1;

        // 1. Idle line holds everything
        for (int i = 0; i < 10; i++) step(1'b1);
        chk_data("idle_data", 8'h00);
        chk_rdy("idle_rdy", 1'b0);

        // 2. Start bit then 1,1,1,0,0
        step(1'b0);
        chk_data("start_data_kept", 8'h00);
        step(1'b1);
        chk_data("bit1", 8'h01);
        step(1'b1);
        step(1'b1);
        chk_data("bit3", 8'h07);
        chk_rdy("bit3_rdy", 1'b0);
        step(1'b0);
        step(1'b0);
        chk_data("bit5", 8'b0001_1100);
        chk_rdy("bit5_rdy", 1'b0);

        // 3. Three more zeros complete the word
        step(1'b0);
        step(1'b0);
        chk_rdy("bit7_rdy", 1'b0);
        step(1'b0);
        chk_data("bit8", 8'b1110_0000);
        chk_rdy("bit8_rdy", 1'b1);

        // 4. rdy and data hold through idle
        for (int i = 0; i < 5; i++) step(1'b1);
        chk_data("hold_data", 8'b1110_0000);
        chk_rdy("hold_rdy", 1'b1);

        // 5. Next start bit clears rdy only; first bit shifts into old contents
        step(1'b0);
        chk_rdy("restart_rdy", 1'b0);
        chk_data("restart_data", 8'b1110_0000);
        step(1'b1);
        chk_data("restart_bit1", 8'b1100_0001);
        chk_rdy("restart_bit1_rdy", 1'b0);

        // 6. Three more bits (4 total), then asynchronous reset between edges
        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk_data("partial4", 8'b0000_1101);
        rst_n = 1'b0;
        #0.5;
        chk_data("async_rst_data", 8'h00);
        chk_rdy("async_rst_rdy", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        chk_data("post_rst_idle", 8'h00);

        // Full frame 0xA5 from the reset state
        frame = 8'hA5;
        step(1'b0);
        for (int i = 7; i >= 0; i--) step(frame[i]);
        chk_data("frame_a5", 8'hA5);
        chk_rdy("frame_a5_rdy", 1'b1);

        // Back-to-back: start on the very first idle edge, frame 0x3C
        frame = 8'h3C;
        step(1'b0);
        chk_rdy("b2b_start_rdy", 1'b0);
        for (int i = 7; i >= 0; i--) step(frame[i]);
        chk_data("frame_3c", 8'h3C);
        chk_rdy("frame_3c_rdy", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
